// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - single-cycle RV32I integer ALU with registered broadcast outputs
module alu_unit #(
  parameter int ROB_IDX_W = 4,
  parameter int OP_W      = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  input  logic                 rs_to_alu_ready,
  input  logic [OP_W-1:0]      rs_to_alu_op,
  input  logic [31:0]          rs_to_alu_rs1,
  input  logic [31:0]          rs_to_alu_rs2,
  input  logic [31:0]          rs_to_alu_imm,
  input  logic [31:0]          rs_to_alu_PC,
  input  logic [ROB_IDX_W-1:0] rs_to_alu_rob_index,
  output logic                 alu_ready,
  output logic [31:0]          alu_result,
  output logic [ROB_IDX_W-1:0] alu_rob_index,
  output logic                 alu_jump,
  output logic [31:0]          alu_target_PC
);

  // Op encodings shared with the reservation station; 0 and unused codes are unrecognised.
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

  logic [31:0] a, b, i;
  logic [31:0] pc_plus4, br_target;
  logic [31:0] nxt_result, nxt_target;
  logic        nxt_jump, taken;

  assign a         = rs_to_alu_rs1;
  assign b         = rs_to_alu_rs2;
  assign i         = rs_to_alu_imm;
  assign pc_plus4  = rs_to_alu_PC + 32'd4;
  assign br_target = rs_to_alu_PC + rs_to_alu_imm;

  // Decode the op into next result, taken flag and target PC.
  always_comb begin
    nxt_result = 32'd0;
    nxt_jump   = 1'b0;
    nxt_target = pc_plus4;
    taken      = 1'b0;
    case (rs_to_alu_op)
      OP_LUI:   nxt_result = i;
      OP_AUIPC: nxt_result = br_target;
      OP_JAL: begin
        nxt_result = pc_plus4;
        nxt_jump   = 1'b1;
        nxt_target = br_target;
      end
      OP_JALR: begin
        nxt_result = pc_plus4;
        nxt_jump   = 1'b1;
        nxt_target = (a + i) & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (rs_to_alu_op)
          OP_BEQ:  taken = (a == b);
          OP_BNE:  taken = (a != b);
          OP_BLT:  taken = ($signed(a) < $signed(b));
          OP_BGE:  taken = ($signed(a) >= $signed(b));
          OP_BLTU: taken = (a < b);
          default: taken = (a >= b);
        endcase
        nxt_jump   = taken;
        nxt_target = taken ? br_target : pc_plus4;
      end
      OP_ADDI:  nxt_result = a + i;
      OP_SLTI:  nxt_result = {31'd0, $signed(a) < $signed(i)};
      OP_SLTIU: nxt_result = {31'd0, a < i};
      OP_XORI:  nxt_result = a ^ i;
      OP_ORI:   nxt_result = a | i;
      OP_ANDI:  nxt_result = a & i;
      OP_SLLI:  nxt_result = a << i[4:0];
      OP_SRLI:  nxt_result = a >> i[4:0];
      OP_SRAI:  nxt_result = $signed(a) >>> i[4:0];
      OP_ADD:   nxt_result = a + b;
      OP_SUB:   nxt_result = a - b;
      OP_SLL:   nxt_result = a << b[4:0];
      OP_SLT:   nxt_result = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:  nxt_result = {31'd0, a < b};
      OP_XOR:   nxt_result = a ^ b;
      OP_SRL:   nxt_result = a >> b[4:0];
      OP_SRA:   nxt_result = $signed(a) >>> b[4:0];
      OP_OR:    nxt_result = a | b;
      OP_AND:   nxt_result = a & b;
      default:  nxt_result = 32'd0;
    endcase
  end

  // Broadcast register: flush wins over a new op; idle cycles only drop the valid pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      alu_ready     <= 1'b0;
      alu_result    <= 32'd0;
      alu_rob_index <= '0;
      alu_jump      <= 1'b0;
      alu_target_PC <= 32'd0;
    end else if (rdy_in) begin
      if (clr_in) begin
        alu_ready <= 1'b0;
        alu_jump  <= 1'b0;
      end else if (rs_to_alu_ready) begin
        alu_ready     <= 1'b1;
        alu_result    <= nxt_result;
        alu_rob_index <= rs_to_alu_rob_index;
        alu_jump      <= nxt_jump;
        alu_target_PC <= nxt_target;
      end else begin
        alu_ready <= 1'b0;
      end
    end
  end

endmodule
